// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator entry controller and its helpers:
//   - keypad codes delivered by the keypad decoder (digits are 0x0..0x9)
//   - one-hot operation encodings presented to the ALU on `operation`
//   - the entry controller state enumeration
//   - small key classification helpers used by the controller
// No ports; import with `import calc_pkg::*;`.
// ---------------------------------------------------------------------------
package calc_pkg;

  // Keypad codes. Anything from 0x0 to 0x9 is a digit.
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_MUL = 4'hB;
  localparam logic [3:0] KEY_DIV = 4'hC;
  localparam logic [3:0] KEY_CLR = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_NOP = 4'hF;

  localparam logic [3:0] MAX_DIGIT = 4'd9;

  // One-hot operation codes as the ALU expects them.
  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0100;

  // Entry controller states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_A,
    ST_GOT_OP,
    ST_GOT_B,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } state_t;

  // True for the ten digit keys.
  function automatic logic is_digit(input logic [3:0] key);
    return key <= MAX_DIGIT;
  endfunction

  // True for the three arithmetic operator keys.
  function automatic logic is_operator(input logic [3:0] key);
    return (key == KEY_ADD) || (key == KEY_MUL) || (key == KEY_DIV);
  endfunction

  // Maps an operator key onto the ALU operation code. Non-operator keys map
  // to OP_NONE so a stray call can never select an arithmetic function.
  function automatic logic [3:0] key_to_op(input logic [3:0] key);
    logic [3:0] op;
    case (key)
      KEY_ADD: op = OP_ADD;
      KEY_MUL: op = OP_MUL;
      KEY_DIV: op = OP_DIV;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_wait_timer.sv
// ---------------------------------------------------------------------------
// calc_wait_timer
// Cycle counter used by the entry controller while it waits for the ALU.
// The count is cleared by `clear`, advances by one on each enabled cycle and
// saturates at TIMEOUT-1 so it can never wrap back into the settle window.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset (count -> 0)
//   clear    in   synchronous clear, has priority over enable
//   enable   in   count this cycle
//   settled  out  count >= SETTLE: an ALU done flag may be trusted
//   expired  out  the count reaches TIMEOUT-1 on the coming edge, so this is
//                 the last cycle in which a done flag can still be accepted
// ---------------------------------------------------------------------------
module calc_wait_timer #(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic settled,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [CW-1:0] LAST_C   = CW'(TIMEOUT - 2);
  localparam logic [CW-1:0] MAX_C    = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // The count starts at zero on the first waiting cycle (it is cleared while
  // the controller issues) and then tracks how many waiting cycles have
  // already passed. Saturation keeps it pinned once the window has closed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != MAX_C)) begin
      count <= count + CW'(1);
    end
  end

  // A done flag seen during the first SETTLE waiting cycles may be left over
  // from the previous operation, so it only counts once settled is high.
  assign settled = (count >= SETTLE_C);

  // Flagging one count early lets the controller's registered state land in
  // ERR exactly when the count would read TIMEOUT-1.
  assign expired = (count >= LAST_C);

endmodule

// File: rtl/calc_entry_ctrl.sv
// ---------------------------------------------------------------------------
// calc_entry_ctrl
// Keypad-to-ALU entry controller. Collects operand A, an operator and
// operand B from single-cycle key strobes, launches the ALU with a one-cycle
// alu_sel/wr_enable pulse on equals, waits for a settled alu_done and latches
// the 8-bit ALU result for the display stage. Divide by zero and an ALU that
// never answers both park the controller in an error state until clear.
//
// Parameters:
//   SETTLE   waiting cycles during which alu_done is ignored
//   TIMEOUT  waiting cycles allowed before the controller gives up
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   key_valid     in   one-cycle strobe qualifying key_code
//   key_code [4]  in   0-9 digit, A add, B mul, C div, D clear, E equals,
//                      F ignored
//   alu_done      in   ALU completion flag
//   alu_result[8] in   ALU uncoded result
//   first_nr  [4] out  operand A (registered)
//   second_nr [4] out  operand B (registered)
//   operation [4] out  one-hot operation, 0000 when none selected
//   alu_sel       out  ALU start pulse
//   wr_enable     out  ALU operand load pulse, coincident with alu_sel
//   result    [8] out  last accepted ALU result
//   result_valid  out  one-cycle pulse when result updates
//   busy          out  high while issuing and waiting
//   error         out  high in the error state
// ---------------------------------------------------------------------------
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       alu_done,
  input  logic [7:0] alu_result,
  output logic [3:0] first_nr,
  output logic [3:0] second_nr,
  output logic [3:0] operation,
  output logic       alu_sel,
  output logic       wr_enable,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       busy,
  output logic       error
);

  state_t state;

  logic key_clr;
  logic key_digit;
  logic key_oper;
  logic key_equals;
  logic timer_clear;
  logic timer_enable;
  logic settled;
  logic expired;
  logic done_accept;
  logic div_by_zero;

  // Key decode. Every key is qualified by the strobe; 0xF never matches any
  // of these and therefore falls through every state untouched.
  assign key_clr    = key_valid && (key_code == KEY_CLR);
  assign key_digit  = key_valid && is_digit(key_code);
  assign key_oper   = key_valid && is_operator(key_code);
  assign key_equals = key_valid && (key_code == KEY_EQ);

  // The timer is zeroed during the issue cycle so the first waiting cycle
  // reads zero, and also on clear so an aborted wait leaves nothing behind.
  assign timer_clear  = key_clr || (state == ST_ISSUE);
  assign timer_enable = (state == ST_WAIT);

  calc_wait_timer #(
    .SETTLE  (SETTLE),
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .settled (settled),
    .expired (expired)
  );

  // Only a done flag that survives the settle window counts; earlier ones
  // are assumed to belong to the operation before this one.
  assign done_accept = alu_done && settled;

  // Division by zero is caught before the ALU is ever started.
  assign div_by_zero = (operation == OP_DIV) && (second_nr == 4'd0);

  // Main controller: state and every output live in this one block so all
  // outputs are registered and alu_sel cannot glitch out of reset. The pulse
  // outputs default low each cycle and are only raised on the transition
  // that calls for them. Clear is checked before the state case so it wins
  // over everything else, including an alu_done in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      first_nr     <= 4'd0;
      second_nr    <= 4'd0;
      operation    <= OP_NONE;
      alu_sel      <= 1'b0;
      wr_enable    <= 1'b0;
      result       <= 8'd0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
    end else begin
      alu_sel      <= 1'b0;
      wr_enable    <= 1'b0;
      result_valid <= 1'b0;

      if (key_clr) begin
        state     <= ST_IDLE;
        first_nr  <= 4'd0;
        second_nr <= 4'd0;
        operation <= OP_NONE;
        result    <= 8'd0;
        busy      <= 1'b0;
        error     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (key_digit) begin
              first_nr <= key_code;
              state    <= ST_GOT_A;
            end
          end

          ST_GOT_A: begin
            if (key_digit) begin
              first_nr <= key_code;
            end else if (key_oper) begin
              operation <= key_to_op(key_code);
              state     <= ST_GOT_OP;
            end
          end

          ST_GOT_OP: begin
            if (key_oper) begin
              operation <= key_to_op(key_code);
            end else if (key_digit) begin
              second_nr <= key_code;
              state     <= ST_GOT_B;
            end
          end

          ST_GOT_B: begin
            if (key_digit) begin
              second_nr <= key_code;
            end else if (key_equals) begin
              if (div_by_zero) begin
                error <= 1'b1;
                state <= ST_ERR;
              end else begin
                alu_sel   <= 1'b1;
                wr_enable <= 1'b1;
                busy      <= 1'b1;
                state     <= ST_ISSUE;
              end
            end
          end

          ST_ISSUE: begin
            state <= ST_WAIT;
          end

          ST_WAIT: begin
            if (done_accept) begin
              result       <= alu_result;
              result_valid <= 1'b1;
              busy         <= 1'b0;
              state        <= ST_DONE;
            end else if (expired) begin
              busy  <= 1'b0;
              error <= 1'b1;
              state <= ST_ERR;
            end
          end

          ST_DONE: begin
            if (key_digit) begin
              first_nr  <= key_code;
              second_nr <= 4'd0;
              operation <= OP_NONE;
              state     <= ST_GOT_A;
            end
          end

          ST_ERR: begin
            state <= ST_ERR;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// ---------------------------------------------------------------------------
// tb_calc_entry_ctrl
// Scoreboard bench for the calculator entry controller. The reference model
// keeps operands as plain integers (-1 meaning "not entered yet") plus done
// and error flags, and derives ALU acceptance and timeout cycles directly
// from the cycle arithmetic. Expected ALU launches, results and error entries
// are queued with the cycle they must appear in; a negedge monitor pops and
// compares them whenever the DUT produces one.
// ---------------------------------------------------------------------------
module tb_calc_entry_ctrl;

  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'hF;
  logic       alu_done = 1'b0;
  logic [7:0] alu_result = 8'd0;
  logic [3:0] first_nr;
  logic [3:0] second_nr;
  logic [3:0] operation;
  logic       alu_sel;
  logic       wr_enable;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;
  logic       error;

  calc_entry_ctrl #(
    .SETTLE  (SETTLE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .alu_done     (alu_done),
    .alu_result   (alu_result),
    .first_nr     (first_nr),
    .second_nr    (second_nr),
    .operation    (operation),
    .alu_sel      (alu_sel),
    .wr_enable    (wr_enable),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .error        (error)
  );

  // Free-running clock and a cycle counter that reads k during cycle k.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard entries: kind 0 = ALU launch, 1 = result, 2 = error entry.
  typedef struct {
    int kind;
    int cyc;
    int a;
    int b;
    int op;
    int res;
  } exp_t;

  exp_t expq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_a   = -1;
  int m_b   = -1;
  int m_op  = 0;
  int m_res = 0;
  bit m_done = 1'b0;
  bit m_err  = 1'b0;
  bit issued = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int op_of(input int k);
    if (k == 10) return 1;
    if (k == 11) return 2;
    return 4;
  endfunction

  task automatic model_reset();
    m_a    = -1;
    m_b    = -1;
    m_op   = 0;
    m_res  = 0;
    m_done = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic push_exp(input int kind, input int c, input int res);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.a    = (m_a < 0) ? 0 : m_a;
    e.b    = (m_b < 0) ? 0 : m_b;
    e.op   = m_op;
    e.res  = res;
    expq.push_back(e);
  endtask

  // Effect of one key strobed in cycle n on an idle (not waiting) calculator.
  task automatic model_key(input int k, input int n);
    issued = 1'b0;
    if (k == 13) begin
      model_reset();
    end else if (k == 15 || m_err) begin
    end else if (k <= 9) begin
      if (m_done) begin
        m_a    = k;
        m_b    = -1;
        m_op   = 0;
        m_done = 1'b0;
      end else if (m_op == 0) begin
        m_a = k;
      end else begin
        m_b = k;
      end
    end else if (k <= 12) begin
      if (!m_done && m_a >= 0 && m_b < 0) m_op = op_of(k);
    end else if (k == 14) begin
      if (!m_done && m_b >= 0) begin
        if (m_op == 4 && m_b == 0) begin
          m_err = 1'b1;
          push_exp(2, n + 1, 0);
        end else begin
          issued = 1'b1;
          push_exp(0, n + 1, 0);
        end
      end
    end
  endtask

  task automatic checkOutput(input bit busy_req);
    check("first_nr", first_nr, (m_a < 0) ? 0 : m_a);
    check("second_nr", second_nr, (m_b < 0) ? 0 : m_b);
    check("operation", operation, m_op);
    check("result", result, m_res);
    check("busy", busy, busy_req);
    check("error", error, m_err);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_first_nr"}, first_nr, 0);
    check({tag, "_second_nr"}, second_nr, 0);
    check({tag, "_operation"}, operation, 0);
    check({tag, "_alu_sel"}, alu_sel, 0);
    check({tag, "_wr_enable"}, wr_enable, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_error"}, error, 0);
  endtask

  // Strobes one key. Starts and ends just after a rising edge. When the key
  // launches the ALU it returns in the issue cycle so runIssue can take over.
  task automatic applyStimulus(input int k);
    int n;
    int gap;
    key_valid = 1'b1;
    key_code  = k[3:0];
    n = cyc;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'hF;
    model_key(k, n);
    if (!issued) begin
      @(negedge clk);
      checkOutput(1'b0);
      gap = $urandom_range(0, 2);
      repeat (gap + 1) @(posedge clk);
      #1;
    end
  endtask

  // Drives alu_done / alu_result from the issue cycle on (rel 0 = issue).
  // mode 0: never done; 1: one-cycle pulse at rel d; 2: held high rel 0..d.
  // clr_rel / rst_rel >= 0 abort with clear / async reset in that cycle.
  task automatic runIssue(input int mode, input int d, input int clr_rel,
                          input int rst_rel, input int fixed_res);
    bit in_flight;
    int end_rel;
    in_flight = 1'b1;
    end_rel   = 0;
    for (int rel = 0; rel <= TIMEOUT + 2; rel++) begin
      bit dn;
      int v;
      int j;
      dn = (mode == 1 && rel == d) || (mode == 2 && rel <= d);
      v  = (fixed_res >= 0) ? fixed_res : $urandom_range(0, 255);
      alu_done   = dn;
      alu_result = v[7:0];
      if (in_flight && rel == clr_rel) begin
        key_valid = 1'b1;
        key_code  = 4'hD;
      end else if (in_flight && rel != rst_rel && $urandom_range(0, 9) == 0) begin
        j = $urandom_range(0, 14);
        if (j == 13) j = 15;
        key_valid = 1'b1;
        key_code  = j[3:0];
      end else begin
        key_valid = 1'b0;
      end
      @(negedge clk);
      checkOutput(in_flight);
      if (in_flight && rel == rst_rel) begin
        #1;
        rst = 1'b1;
        key_valid = 1'b0;
        #1;
        checkAllZero("async_rst");
        model_reset();
        in_flight = 1'b0;
        end_rel   = rel;
        #1;
        rst = 1'b0;
      end else if (in_flight) begin
        if (rel == clr_rel) begin
          model_reset();
          in_flight = 1'b0;
          end_rel   = rel;
        end else if (dn && rel >= 1 + SETTLE && rel <= TIMEOUT - 1) begin
          m_res  = v;
          m_done = 1'b1;
          push_exp(1, cyc + 1, v);
          in_flight = 1'b0;
          end_rel   = rel;
        end else if (rel == TIMEOUT - 1) begin
          m_err = 1'b1;
          push_exp(2, cyc + 1, 0);
          in_flight = 1'b0;
          end_rel   = rel;
        end
      end
      @(posedge clk);
      #1;
      if (!in_flight && rel >= end_rel + 2) break;
    end
    alu_done  = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'hF;
  endtask

  // Monitor: every DUT event must match the head of the scoreboard queue,
  // both in kind and in the cycle it appears.
  task automatic popCheck(input int kind);
    exp_t e;
    if (expq.size() == 0) begin
      check("unexpected_event_kind", kind, -1);
    end else begin
      e = expq.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cyc);
      if (kind == 0) begin
        check("issue_alu_sel", alu_sel, 1);
        check("issue_wr_enable", wr_enable, 1);
        check("issue_first_nr", first_nr, e.a);
        check("issue_second_nr", second_nr, e.b);
        check("issue_operation", operation, e.op);
      end else if (kind == 1) begin
        check("result_value", result, e.res);
      end
    end
  endtask

  bit prev_err = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_err = 1'b0;
    end else begin
      if (alu_sel || wr_enable) popCheck(0);
      if (result_valid) popCheck(1);
      if (error && !prev_err) popCheck(2);
      prev_err = error;
    end
  end

  // Hard stop in case the design wedges the bench.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int r;
    int mode;
    int d;
    int clr_rel;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] 3 + 4 with done at issue+4");
    applyStimulus(3); applyStimulus(10); applyStimulus(4); applyStimulus(14);
    if (issued) runIssue(1, 4, -1, -1, 8'h07);

    $display("[TB] 9 * 9 with stale done held from issue");
    applyStimulus(9); applyStimulus(11); applyStimulus(9); applyStimulus(14);
    if (issued) runIssue(2, 6, -1, -1, 8'h51);

    $display("[TB] 5 / 0 then clear");
    applyStimulus(5); applyStimulus(12); applyStimulus(0); applyStimulus(14);
    applyStimulus(13);

    $display("[TB] 2 + 1 with no done: timeout");
    applyStimulus(2); applyStimulus(10); applyStimulus(1); applyStimulus(14);
    if (issued) runIssue(0, 0, -1, -1, -1);
    applyStimulus(13);

    $display("[TB] 7 + 8 aborted by clear during wait");
    applyStimulus(7); applyStimulus(10); applyStimulus(8); applyStimulus(14);
    if (issued) runIssue(1, 5, 3, -1, -1);

    $display("[TB] 1 + * 6, new entry from done, reset mid-wait");
    applyStimulus(1); applyStimulus(10); applyStimulus(11); applyStimulus(6);
    applyStimulus(14);
    if (issued) runIssue(1, 4, -1, -1, -1);
    applyStimulus(4);
    applyStimulus(10); applyStimulus(2); applyStimulus(14);
    if (issued) runIssue(0, 0, -1, 3, -1);

    $display("[TB] random key stream");
    for (int step = 0; step < 300; step++) begin
      r = $urandom_range(0, 99);
      if (m_err && r < 30)  k = 13;
      else if (r < 40)      k = $urandom_range(0, 9);
      else if (r < 65)      k = $urandom_range(10, 12);
      else if (r < 85)      k = 14;
      else if (r < 95)      k = 15;
      else                  k = 13;
      applyStimulus(k);
      if (issued) begin
        r = $urandom_range(0, 99);
        if (r < 10) begin
          mode = 0; d = 0;
        end else if (r < 60) begin
          mode = 1; d = $urandom_range(0, TIMEOUT + 2);
        end else begin
          mode = 2; d = $urandom_range(0, 12);
        end
        clr_rel = ($urandom_range(0, 99) < 15) ? $urandom_range(0, TIMEOUT - 1) : -1;
        runIssue(mode, d, clr_rel, -1, -1);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
